// File: rtl/cd_isa_pkg.sv
// Constants and frame helpers shared by the controller<->PDU serial link (tx and rx sides).
package cd_isa_pkg;

  localparam int         CTRL_FRAME_BYTES = 9;
  localparam logic [7:0] CTRL_SYNC_BYTE   = 8'hA5;

  localparam int FLG_MPU_LSB = 0;
  localparam int FLG_STF     = 2;
  localparam int FLG_STR     = 3;
  localparam int FLG_STOP    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] pack_flags(input logic [1:0] mpu, input logic stf,
                                            input logic str, input logic stop);
    logic [7:0] f;
    f                    = 8'h00;
    f[FLG_MPU_LSB +: 2]  = mpu;
    f[FLG_STF]           = stf;
    f[FLG_STR]           = str;
    f[FLG_STOP]          = stop;
    return f;
  endfunction

  // Checksum covers the payload only; the sync byte is deliberately excluded.
  function automatic logic [7:0] payload_xor(input logic [55:0] payload);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 7; i++) begin
      x = x ^ payload[8*i +: 8];
    end
    return x;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first. Accepts the next byte in the last stop-bit cycle so
// consecutive bytes leave the line with no idle gap.
module uart_tx_byte
  import cd_isa_pkg::*;
#(
  parameter int CLK_DIV = 417
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       byte_valid_in,
  input  logic [7:0] byte_in,
  output logic       byte_ready_out,
  output logic       stop_end_out,
  output logic       tx_out
);

  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_d          = bit_q;
    shift_d        = shift_q;
    tx_d           = tx_q;
    byte_ready_out = 1'b0;
    stop_end_out   = 1'b0;
    case (state_q)
      IDLE: begin
        byte_ready_out = 1'b1;
        if (byte_valid_in) begin
          state_d = START;
          cnt_d   = RELOAD;
          shift_d = byte_in;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          state_d = DATA;
          cnt_d   = RELOAD;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = RELOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          stop_end_out   = 1'b1;
          byte_ready_out = 1'b1;
          if (byte_valid_in) begin
            state_d = START;
            cnt_d   = RELOAD;
            shift_d = byte_in;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_out = tx_q;

endmodule

// File: rtl/if_ctrl2pdu_tx.sv
// Controller-side RS485 frame transmitter: snapshots encoder/KA/flags on a strobe and
// sends SYNC, 7 payload bytes and an XOR checksum as one 9-byte 8N1 frame.
module if_ctrl2pdu_tx
  import cd_isa_pkg::*;
#(
  parameter int         CLK_DIV   = 417,
  parameter logic [7:0] SYNC_BYTE = CTRL_SYNC_BYTE
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        f100_in,
  input  logic [31:0] enc_in,
  input  logic [15:0] ka_status_in,
  input  logic [1:0]  mpu_status_in,
  input  logic        stf_in,
  input  logic        str_in,
  input  logic        stop_in,
  output logic        rs_tx_out,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        drop_out
);

  localparam logic [3:0] LAST_IDX = 4'(CTRL_FRAME_BYTES - 1);

  logic [55:0] shadow_q, shadow_d;
  logic [7:0]  csum_q, csum_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic        pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        drop_q, drop_d;

  logic        byte_ready;
  logic        stop_end;
  logic [7:0]  tx_byte;
  logic [55:0] payload;

  assign payload = {enc_in, ka_status_in, pack_flags(mpu_status_in, stf_in, str_in, stop_in)};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      shadow_q   <= 56'd0;
      csum_q     <= 8'h00;
      byte_idx_q <= 4'd0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      csum_q     <= csum_d;
      byte_idx_q <= byte_idx_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  // pending_q means "a byte at byte_idx_q still has to be handed to the serialiser";
  // busy_q stays high until the serialiser finishes the checksum's stop bit.
  always_comb begin
    shadow_d   = shadow_q;
    csum_d     = csum_q;
    byte_idx_d = byte_idx_q;
    pending_d  = pending_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    if (f100_in) begin
      if (busy_q) begin
        drop_d = 1'b1;
      end else begin
        shadow_d   = payload;
        csum_d     = payload_xor(payload);
        byte_idx_d = 4'd0;
        pending_d  = 1'b1;
        busy_d     = 1'b1;
      end
    end
    if (pending_q && byte_ready) begin
      if (byte_idx_q == LAST_IDX) begin
        pending_d = 1'b0;
      end else begin
        byte_idx_d = byte_idx_q + 4'd1;
      end
    end
    if (busy_q && !pending_q && stop_end) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_comb begin
    tx_byte = SYNC_BYTE;
    case (byte_idx_q)
      4'd1:    tx_byte = shadow_q[55:48];
      4'd2:    tx_byte = shadow_q[47:40];
      4'd3:    tx_byte = shadow_q[39:32];
      4'd4:    tx_byte = shadow_q[31:24];
      4'd5:    tx_byte = shadow_q[23:16];
      4'd6:    tx_byte = shadow_q[15:8];
      4'd7:    tx_byte = shadow_q[7:0];
      4'd8:    tx_byte = csum_q;
      default: tx_byte = SYNC_BYTE;
    endcase
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_ser (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .byte_valid_in (pending_q),
    .byte_in       (tx_byte),
    .byte_ready_out(byte_ready),
    .stop_end_out  (stop_end),
    .tx_out        (rs_tx_out)
  );

  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign drop_out       = drop_q;

endmodule

// File: tb/tb_if_ctrl2pdu_tx.sv
// Randomised frame bench for if_ctrl2pdu_tx (CLK_DIV=4): a line receiver decodes the
// serial output and each frame is compared with bytes built from the strobed inputs.
module tb_if_ctrl2pdu_tx;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f100_in = 1'b0;
  logic [31:0] enc_in = '0;
  logic [15:0] ka_status_in = '0;
  logic [1:0]  mpu_status_in = '0;
  logic        stf_in = 1'b0, str_in = 1'b0, stop_in = 1'b0;
  logic        rs_tx_out, busy_out, frame_done_out, drop_out;

  int n_checks = 0;
  int n_errors = 0;
  int rx_stop_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_byte;

  always #5 clk = ~clk;

  if_ctrl2pdu_tx #(.CLK_DIV(DIV)) dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .f100_in       (f100_in),
    .enc_in        (enc_in),
    .ka_status_in  (ka_status_in),
    .mpu_status_in (mpu_status_in),
    .stf_in        (stf_in),
    .str_in        (str_in),
    .stop_in       (stop_in),
    .rs_tx_out     (rs_tx_out),
    .busy_out      (busy_out),
    .frame_done_out(frame_done_out),
    .drop_out      (drop_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Line receiver: samples mid-bit, DIV cycles per bit.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rs_tx_out == 1'b0) begin
        repeat (DIV + DIV/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx_byte[i] = rs_tx_out;
          if (i < 7) repeat (DIV) @(negedge clk);
        end
        repeat (DIV) @(negedge clk);
        if (rs_tx_out !== 1'b1) rx_stop_err++;
        rx_q.push_back(rx_byte);
      end
    end
  end

  function automatic void model_frame(input logic [31:0] enc, input logic [15:0] ka,
                                      input logic [1:0] mpu, input logic stf,
                                      input logic str, input logic stp);
    logic [7:0] b[9];
    logic [7:0] x;
    b[0] = 8'hA5;
    for (int i = 0; i < 4; i++) b[1+i] = 8'((enc >> (24 - 8*i)) & 32'hFF);
    b[5] = ka[15:8];
    b[6] = ka[7:0];
    b[7] = 8'(16*int'(stp) + 8*int'(str) + 4*int'(stf) + int'(mpu));
    x = 8'h00;
    for (int i = 1; i < 8; i++) x = x ^ b[i];
    b[8] = x;
    for (int i = 0; i < 9; i++) exp_q.push_back(b[i]);
  endfunction

  // Called at a negedge; the following posedge is the strobe edge.
  task automatic start_frame(input logic [31:0] enc, input logic [15:0] ka,
                             input logic [1:0] mpu, input logic stf, input logic str,
                             input logic stp, input bit corrupt);
    enc_in = enc; ka_status_in = ka; mpu_status_in = mpu;
    stf_in = stf; str_in = str; stop_in = stp;
    model_frame(enc, ka, mpu, stf, str, stp);
    f100_in = 1'b1;
    @(negedge clk);
    f100_in = 1'b0;
    if (corrupt) begin
      enc_in = 32'hFFFF_FFFF;
      ka_status_in = ~ka;
      stop_in = ~stp;
    end
    check("busy_rise", {31'd0, busy_out}, 32'd1);
    check("line_before_start", {31'd0, rs_tx_out}, 32'd1);
  endtask

  // Runs to frame_done; optionally strobes so that the strobe edge is E<drop_at>.
  task automatic finish_frame(input int drop_at, input string tag);
    int k;
    int drops;
    drops = 0;
    for (k = 1; k <= 1000; k++) begin
      @(negedge clk);
      f100_in = (k == drop_at - 1);
      if (k == 1) check({tag, "_start_bit"}, {31'd0, rs_tx_out}, 32'd0);
      if (drop_out) drops++;
      if (frame_done_out) break;
    end
    f100_in = 1'b0;
    check({tag, "_done_cycle"}, 32'(k), 32'(90*DIV + 1));
    check({tag, "_drops"}, 32'(drops), (drop_at != 0) ? 32'd1 : 32'd0);
    check({tag, "_busy_fall"}, {31'd0, busy_out}, 32'd0);
    check({tag, "_nbytes"}, 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < rx_q.size()) check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    end
    $display("frame %s: enc=%h ka=%h done@%0d drops=%0d", tag, enc_in, ka_status_in, k, drops);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic idle_check(input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rs_tx_out !== 1'b1 || busy_out !== 1'b0 || frame_done_out !== 1'b0 || drop_out !== 1'b0)
        bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit chain;
    int da;
    repeat (3) @(negedge clk);
    check("rst_line", {31'd0, rs_tx_out}, 32'd1);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    rst_n = 1'b1;
    idle_check(100, "idle_after_reset");

    start_frame(32'h1234_5678, 16'hABCD, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    finish_frame(0, "basic");

    repeat (3) @(negedge clk);
    start_frame(32'h1234_5678, 16'hABCD, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    finish_frame(0, "snapshot");

    repeat (3) @(negedge clk);
    start_frame(32'hCAFE_0001, 16'h0F0F, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    finish_frame(100, "drop_mid");
    start_frame(32'h8000_0002, 16'h1234, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    finish_frame(90*DIV + 1, "drop_on_done");
    start_frame(32'h0BAD_F00D, 16'h5A5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    finish_frame(0, "back_to_back");

    repeat (3) @(negedge clk);
    start_frame(32'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (149) @(negedge clk);
    check("line_before_reset", {31'd0, rs_tx_out}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_line", {31'd0, rs_tx_out}, 32'd1);
    check("async_rst_busy", {31'd0, busy_out}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_check(100, "idle_after_abort");
    rx_q.delete();
    exp_q.delete();
    rx_stop_err = 0;
    start_frame(32'h1234_5678, 16'hABCD, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    finish_frame(0, "after_abort");

    repeat (2) @(negedge clk);
    start_frame(32'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_frame(0, "all_zero");
    repeat (2) @(negedge clk);
    start_frame(32'hFFFF_FFFF, 16'hFFFF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    finish_frame(0, "all_ones");

    chain = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (!chain) repeat ($urandom_range(1, 6)) @(negedge clk);
      start_frame($urandom, 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom_range(0, 1)));
      da = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 90*DIV + 1));
      finish_frame(da, $sformatf("rnd%0d", r));
      chain = 1'($urandom_range(0, 1));
    end

    idle_check(20, "final_idle");
    check("stop_bits", 32'(rx_stop_err), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
